// File: rtl/vc_demux_ctrl.sv
// vc_demux_ctrl: drains the main FIFO and steers each word to VC0 or VC1
// according to bit VC_SEL_BIT of the word. A word whose target VC is paused
// is parked in a one-entry holding register until that VC accepts it.
// Optional push statistics are compiled in when VC_DEMUX_STATS_EN is defined;
// otherwise cnt_vc0/cnt_vc1 are tied to zero.
module vc_demux_ctrl #(
  parameter int DATA_SIZE  = 6,
  parameter int VC_SEL_BIT = 5,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 fifo_empty_main,
  input  logic [DATA_SIZE-1:0] data_demux_vc,
  input  logic                 pause_vc0,
  input  logic                 pause_vc1,
  output logic                 pop_main,
  output logic                 push_vc0,
  output logic                 push_vc1,
  output logic [DATA_SIZE-1:0] data_vc0,
  output logic [DATA_SIZE-1:0] data_vc1,
  output logic                 stall,
  output logic [CNT_W-1:0]     cnt_vc0,
  output logic [CNT_W-1:0]     cnt_vc1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [DATA_SIZE-1:0] hold_q;
  logic [DATA_SIZE-1:0] eval_word;
  logic                 eval_tgt;
  logic                 eval_paused;
  logic                 fire;
  logic                 pop;

  // Pick the word under evaluation (arriving word in WAIT, parked word in HOLD)
  always_comb begin
    eval_word = {DATA_SIZE{1'b0}};
    case (state_q)
      ST_WAIT: eval_word = data_demux_vc;
      ST_HOLD: eval_word = hold_q;
      default: eval_word = {DATA_SIZE{1'b0}};
    endcase
    eval_tgt = eval_word[VC_SEL_BIT];
    if (eval_tgt) begin
      eval_paused = pause_vc1;
    end else begin
      eval_paused = pause_vc0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; also decides whether a word fires and whether to pop
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pop = !fifo_empty_main;
        if (pop) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT, ST_HOLD: begin
        if (!eval_paused) begin
          fire = 1'b1;
          pop  = !fifo_empty_main;
          if (pop) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          pop     = 1'b0;
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pop     = 1'b0;
        fire    = 1'b0;
      end
    endcase
  end

  // Output decode: the pop strobe is suppressed while reset is asserted
  always_comb begin
    if (reset_L) begin
      pop_main = pop;
    end else begin
      pop_main = 1'b0;
    end
  end

  // Parking register, registered VC pushes/data and the HOLD status flag
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      hold_q   <= {DATA_SIZE{1'b0}};
      push_vc0 <= 1'b0;
      push_vc1 <= 1'b0;
      data_vc0 <= {DATA_SIZE{1'b0}};
      data_vc1 <= {DATA_SIZE{1'b0}};
      stall    <= 1'b0;
    end else begin
      if ((state_q == ST_WAIT) && eval_paused) begin
        hold_q <= data_demux_vc;
      end else begin
        hold_q <= hold_q;
      end
      push_vc0 <= fire && !eval_tgt;
      push_vc1 <= fire && eval_tgt;
      if (fire && !eval_tgt) begin
        data_vc0 <= eval_word;
      end else begin
        data_vc0 <= data_vc0;
      end
      if (fire && eval_tgt) begin
        data_vc1 <= eval_word;
      end else begin
        data_vc1 <= data_vc1;
      end
      // stall mirrors "state is HOLD" in the cycle that state is entered
      stall <= (state_d == ST_HOLD);
    end
  end

`ifdef VC_DEMUX_STATS_EN
  // Push statistics counters, wrapping modulo 2^CNT_W
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      cnt_vc0 <= {CNT_W{1'b0}};
      cnt_vc1 <= {CNT_W{1'b0}};
    end else begin
      if (push_vc0) begin
        cnt_vc0 <= cnt_vc0 + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_vc0 <= cnt_vc0;
      end
      if (push_vc1) begin
        cnt_vc1 <= cnt_vc1 + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_vc1 <= cnt_vc1;
      end
    end
  end
`else
  assign cnt_vc0 = {CNT_W{1'b0}};
  assign cnt_vc1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_vc_demux_ctrl.sv
// Testbench for vc_demux_ctrl: a queue-based main FIFO feeds the DUT and a
// word-level reference model (one word in flight, delivered the first cycle
// its target VC is unpaused) predicts every output each cycle.
module tb_vc_demux_ctrl;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       fifo_empty_main;
  logic [5:0] data_demux_vc;
  logic       pause_vc0;
  logic       pause_vc1;
  logic       pop_main;
  logic       push_vc0;
  logic       push_vc1;
  logic [5:0] data_vc0;
  logic [5:0] data_vc1;
  logic       stall;
  logic [7:0] cnt_vc0;
  logic [7:0] cnt_vc1;

  vc_demux_ctrl #(.DATA_SIZE(6), .VC_SEL_BIT(5), .CNT_W(8)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .fifo_empty_main (fifo_empty_main),
    .data_demux_vc   (data_demux_vc),
    .pause_vc0       (pause_vc0),
    .pause_vc1       (pause_vc1),
    .pop_main        (pop_main),
    .push_vc0        (push_vc0),
    .push_vc1        (push_vc1),
    .data_vc0        (data_vc0),
    .data_vc1        (data_vc1),
    .stall           (stall),
    .cnt_vc0         (cnt_vc0),
    .cnt_vc1         (cnt_vc1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main FIFO contents and reference model state
  logic [5:0] fifo_q[$];
  logic       pend_valid = 1'b0;
  logic [5:0] pend_word  = 6'd0;
  logic       m_push0 = 1'b0, m_push1 = 1'b0, m_stall = 1'b0;
  logic [5:0] m_data0 = 6'd0, m_data1 = 6'd0;
  logic [7:0] m_cnt0 = 8'd0, m_cnt1 = 8'd0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: called just after a falling edge with pauses/reset set.
  task automatic step();
    logic go;
    logic exp_pop;
    logic [7:0] e_cnt0;
    logic [7:0] e_cnt1;
    fifo_empty_main = (fifo_q.size() == 0);
    #1;
    go = 1'b0;
    if (pend_valid) go = pend_word[5] ? !pause_vc1 : !pause_vc0;
    exp_pop = reset_L && !fifo_empty_main && (!pend_valid || go);
`ifdef VC_DEMUX_STATS_EN
    e_cnt0 = m_cnt0;
    e_cnt1 = m_cnt1;
`else
    e_cnt0 = 8'd0;
    e_cnt1 = 8'd0;
`endif
    check("pop_main", 8'(pop_main), 8'(exp_pop));
    check("push_vc0", 8'(push_vc0), 8'(m_push0));
    check("push_vc1", 8'(push_vc1), 8'(m_push1));
    check("data_vc0", 8'(data_vc0), 8'(m_data0));
    check("data_vc1", 8'(data_vc1), 8'(m_data1));
    check("stall",    8'(stall),    8'(m_stall));
    check("cnt_vc0",  cnt_vc0, e_cnt0);
    check("cnt_vc1",  cnt_vc1, e_cnt1);
    if (!reset_L) begin
      pend_valid = 1'b0;
      m_push0 = 1'b0; m_push1 = 1'b0; m_stall = 1'b0;
      m_data0 = 6'd0; m_data1 = 6'd0;
      m_cnt0  = 8'd0; m_cnt1  = 8'd0;
    end else begin
      m_push0 = go && !pend_word[5];
      m_push1 = go && pend_word[5];
      if (m_push0) begin m_data0 = pend_word; m_cnt0 = m_cnt0 + 8'd1; end
      if (m_push1) begin m_data1 = pend_word; m_cnt1 = m_cnt1 + 8'd1; end
      m_stall = pend_valid && !go;
      if (go) pend_valid = 1'b0;
      if (exp_pop) begin
        pend_word  = fifo_q.pop_front();
        pend_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (exp_pop) data_demux_vc = pend_word;
    else         data_demux_vc = 6'($urandom);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_L = 1'b0;
    fifo_empty_main = 1'b1;
    data_demux_vc = 6'd0;
    pause_vc0 = 1'b0;
    pause_vc1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    run(1);
    reset_L = 1'b1;

    // idle with an empty FIFO
    run(10);

    // basic routing, back-to-back
    fifo_q.push_back(6'h05); fifo_q.push_back(6'h25);
    fifo_q.push_back(6'h01); fifo_q.push_back(6'h3F);
    run(8);

    // VC1 paused: word parks, then releases
    pause_vc1 = 1'b1;
    fifo_q.push_back(6'h21); fifo_q.push_back(6'h07);
    run(7);
    pause_vc1 = 1'b0;
    run(5);

    // VC1 paused does not block VC0 traffic
    pause_vc1 = 1'b1;
    fifo_q.push_back(6'h02); fifo_q.push_back(6'h03);
    run(6);
    pause_vc1 = 1'b0;
    run(2);

    // reset while holding a word discards it
    pause_vc1 = 1'b1;
    fifo_q.push_back(6'h2A);
    run(5);
    reset_L = 1'b0;
    run(1);
    reset_L = 1'b1;
    pause_vc1 = 1'b0;
    run(4);

    // 257 VC0 words: counter wraps to 1
    for (int i = 0; i < 257; i++) fifo_q.push_back(6'($urandom_range(0, 31)));
    run(262);

    // randomized traffic with pauses, gaps and occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 4) fifo_q.push_back(6'($urandom));
      pause_vc0 = ($urandom_range(0, 3) == 0);
      pause_vc1 = ($urandom_range(0, 3) == 0);
      reset_L   = ($urandom_range(0, 79) != 0);
      step();
    end
    reset_L = 1'b1;
    pause_vc0 = 1'b0;
    pause_vc1 = 1'b0;
    run(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
